clk_div_gen: RTL and testbench

//   Programmable clock-divider/strobe generator: from system clock clk it produces a

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_cfg.sv | 75 +++++++
 rtl/clk_div_gen.sv | 105 ++++++++++
 tb/tb_clk_div_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, reset defaults and the ratio validity rule for the clk_div_gen divider.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned DEFAULT_DIV_DEF  = 10;
    localparam int unsigned DEFAULT_HIGH_DEF = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // A ratio is usable only if both the high and the low phase last at least one cycle.
    function automatic logic cfg_valid(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'd2) && (high >= 32'd1) && (high < div);
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Ratio configuration: shadow registers filled by validated loads, copied to the
// active ratio on an apply strobe from the sequencer.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV  = DEFAULT_DIV_DEF,
    parameter int unsigned DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load_i,
    input  logic [CNT_W-1:0] div_val_i,
    input  logic [CNT_W-1:0] high_val_i,
    input  logic             apply_i,
    output logic [CNT_W-1:0] div_a_o,
    output logic [CNT_W-1:0] high_n_o,
    output logic             cfg_err_o
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
    logic [CNT_W-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
    logic             cfg_err_q, cfg_err_d;
    logic             req_ok_s;

    // Next-state for shadow, active ratio and the reject pulse; an apply copies the
    // pre-load shadow, so a load on the same edge waits for the following apply.
    always_comb begin
        req_ok_s  = cfg_valid(32'(div_val_i), 32'(high_val_i));
        div_s_d   = div_s_q;
        high_s_d  = high_s_q;
        div_a_d   = div_a_q;
        high_a_d  = high_a_q;
        cfg_err_d = div_load_i && !req_ok_s;
        if (div_load_i && req_ok_s) begin
            div_s_d  = div_val_i;
            high_s_d = high_val_i;
        end else begin
            div_s_d  = div_s_q;
            high_s_d = high_s_q;
        end
        if (apply_i) begin
            div_a_d  = div_s_q;
            high_a_d = high_s_q;
        end else begin
            div_a_d  = div_a_q;
            high_a_d = high_a_q;
        end
    end

    // Configuration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_s_q   <= RST_DIV;
            high_s_q  <= RST_HIGH;
            div_a_q   <= RST_DIV;
            high_a_q  <= RST_HIGH;
            cfg_err_q <= 1'b0;
        end else begin
            div_s_q   <= div_s_d;
            high_s_q  <= high_s_d;
            div_a_q   <= div_a_d;
            high_a_q  <= high_a_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign div_a_o   = div_a_q;
    assign high_n_o  = apply_i ? high_s_q : high_a_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable clock divider: run/drain sequencer, period counter and registered
// clk_out/tick/busy outputs; stops always finish the current period.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV  = DEFAULT_DIV_DEF,
    parameter int unsigned DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] high_val,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, nxt_s;
    logic [CNT_W-1:0] div_a_s, high_n_s;
    logic             clk_out_q, clk_out_d, tick_q, tick_d, busy_q, busy_d;
    logic             wrap_s, apply_s;

    clk_div_cfg #(
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_cfg (
        .clk        (clk),
        .rst        (rst),
        .div_load_i (div_load),
        .div_val_i  (div_val),
        .high_val_i (high_val),
        .apply_i    (apply_s),
        .div_a_o    (div_a_s),
        .high_n_o   (high_n_s),
        .cfg_err_o  (cfg_err)
    );

    // div_a never drops below 2, so div_a-1 cannot underflow.
    assign wrap_s  = (cnt_q == (div_a_s - ONE));
    assign nxt_s   = wrap_s ? '0 : (cnt_q + ONE);
    assign apply_s = (state_q == ST_IDLE) ? enable : wrap_s;

    // Sequencer and counter next-state; the high-phase compare sees the post-copy ratio.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if ((state_q == ST_DRAIN) && wrap_s && !enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = enable ? ST_RUN : ST_DRAIN;
                    cnt_d     = nxt_s;
                    clk_out_d = (nxt_s < high_n_s);
                    tick_d    = (nxt_s == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic,
// every cycle compared against a period-age reference model.
module tb_clk_div_gen;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_val  = 16'd0;
    logic [15:0] high_val = 16'd0;
    logic        clk_out, tick, busy, cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a generator is either idle or some number of cycles into a period.
    bit m_act = 1'b0;
    int m_age = 0;
    int m_div = 10, m_high = 5, m_sdiv = 10, m_shigh = 5;
    bit m_prev_en = 1'b0;
    bit e_out = 1'b0, e_tick = 1'b0, e_busy = 1'b0, e_err = 1'b0;

    clk_div_gen dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .div_load (div_load),
        .div_val  (div_val),
        .high_val (high_val),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic bit req_ok(input int d, input int h);
        return (d >= 2) && (h >= 1) && (h < d);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0; m_age = 0; m_prev_en = 1'b0;
            m_div = 10; m_high = 5; m_sdiv = 10; m_shigh = 5;
            e_out = 1'b0; e_tick = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            e_err = div_load && !req_ok(int'(div_val), int'(high_val));
            if (!m_act) begin
                if (enable) begin
                    m_act = 1'b1; m_age = 0; m_div = m_sdiv; m_high = m_shigh;
                end
            end else if (m_age == m_div - 1) begin
                m_div = m_sdiv; m_high = m_shigh; m_age = 0;
                // stop only if enable was already low before this final edge
                if (!enable && !m_prev_en) m_act = 1'b0;
            end else begin
                m_age++;
            end
            e_busy = m_act;
            e_out  = m_act && (m_age < m_high);
            e_tick = m_act && (m_age == 0);
            if (div_load && req_ok(int'(div_val), int'(high_val))) begin
                m_sdiv = int'(div_val); m_shigh = int'(high_val);
            end
            m_prev_en = enable;
        end
    end

    always @(negedge clk) begin
        check_val("clk_out", int'(clk_out), int'(e_out));
        check_val("tick", int'(tick), int'(e_tick));
        check_val("busy", int'(busy), int'(e_busy));
        check_val("cfg_err", int'(cfg_err), int'(e_err));
    end

    task automatic wait_age(input int k);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(m_act && m_age == k) && n < 200);
        if (n >= 200) check_val("wait_age_timeout", n, k);
    endtask

    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 200);
    endtask

    task automatic count_win(input int len, output int ticks, output int highs);
        ticks = int'(tick); highs = int'(clk_out);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            ticks += int'(tick); highs += int'(clk_out);
        end
    endtask

    task automatic load(input int d, input int h);
        div_load = 1'b1; div_val = 16'(d); high_val = 16'(h);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    initial begin
        int t, h, n, bl;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_clk_out", int'(clk_out), 0);
        check_val("rst_busy", int'(busy), 0);

        // 1: defaults, first tick one clock after enable
        enable = 1'b1;
        @(negedge clk);
        check_val("first_tick", int'(tick), 1);
        count_win(40, t, h);
        check_val("dflt_ticks", t, 4);
        check_val("dflt_highs", h, 20);

        // 2: load 4/1 mid-period, current 10-cycle period completes first
        wait_age(3);
        load(4, 1);
        cycles_to_tick(n);
        check_val("old_period_tail", n, 6);
        count_win(16, t, h);
        check_val("r41_ticks", t, 4);
        check_val("r41_highs", h, 4);

        // 3: restore 10/5, then two rejected loads
        load(10, 5);
        load(1, 1);
        check_val("err_div1", int'(cfg_err), 1);
        load(6, 6);
        check_val("err_high_eq_div", int'(cfg_err), 1);
        @(negedge clk);
        check_val("err_clears", int'(cfg_err), 0);
        cycles_to_tick(n);
        cycles_to_tick(n);
        count_win(20, t, h);
        check_val("keep_ticks", t, 2);
        check_val("keep_highs", h, 10);

        // 4: stop drains to the period end; re-enable in drain has no gap
        wait_age(3);
        enable = 1'b0;
        n = 0; t = 0;
        do begin @(negedge clk); n++; t += int'(tick); end while (busy && n < 50);
        check_val("drain_len", n, 7);
        check_val("drain_ticks", t, 0);
        enable = 1'b1;
        wait_age(3);
        enable = 1'b0;
        wait_age(7);
        enable = 1'b1;
        n = 0; bl = 0;
        do begin @(negedge clk); n++; bl += int'(!busy); end while (!tick && n < 50);
        check_val("no_gap_len", n, 3);
        check_val("no_gap_busy", bl, 0);

        // 5: async reset during the high phase
        wait_age(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_clk_out", int'(clk_out), 0);
        check_val("async_tick", int'(tick), 0);
        check_val("async_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("restart_tick", int'(tick), 1);
        count_win(20, t, h);
        check_val("restart_ticks", t, 2);
        check_val("restart_highs", h, 10);

        // 6: load exactly on the wrap edge
        wait_age(9);
        load(3, 2);
        check_val("wrap_tick", int'(tick), 1);
        cycles_to_tick(n);
        check_val("wrap_old_period", n, 10);
        count_win(3, t, h);
        check_val("wrap_new_highs", h, 2);
        cycles_to_tick(n);
        check_val("wrap_new_period", n, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            div_load = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 3) enable = ~enable;
            else if (r < 9) begin
                div_load = 1'b1;
                div_val  = 16'($urandom_range(0, 9));
                high_val = 16'($urandom_range(0, 9));
            end else if (r == 99 && $urandom_range(0, 9) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);
        div_load = 1'b0;
        enable   = 1'b0;
        repeat (30) @(negedge clk);
        check_val("final_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
